// File: rtl/multiplier_pkg.sv
// Shared width and word types for the shift-add multiplier (sequencer, datapath, top level).
package multiplier_pkg;

    localparam int N_DEF = 8;

    typedef logic [N_DEF-1:0]   operand_t;
    typedef logic [2*N_DEF-1:0] product_t;

endpackage

// File: rtl/multiplier_datapath_adder.sv
// N-bit ripple-carry adder.
// Kept as its own module so it can be swapped for a faster structure without touching the datapath.
module multiplier_datapath_adder
    import multiplier_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] w_carry;

    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign cout = w_carry[N];

endmodule

// File: rtl/multiplier_datapath.sv
// Shift-add multiplier datapath: M, carry C, accumulator A and multiplier/low-product Q.
// Executes sequencer commands and returns Q0 for its add decision.
module multiplier_datapath
    import multiplier_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           clock,
    input  logic           n_reset,
    input  logic           reset,
    input  logic           add,
    input  logic           shift,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           Q0,
    output logic [2*N-1:0] product
);

    logic [N-1:0] r_m;
    logic [N-1:0] r_a;
    logic [N-1:0] r_q;
    logic         r_c;

    logic [N-1:0] w_sum;
    logic         w_cout;

    multiplier_datapath_adder #(.N(N)) u_adder (
        .a    (r_a),
        .b    (r_m),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_m <= '0;
            r_a <= '0;
            r_q <= '0;
            r_c <= 1'b0;
        end else if (reset) begin
            r_m <= multiplicand;
            r_a <= '0;
            r_q <= multiplier;
            r_c <= 1'b0;
        end else if (add && shift) begin
            // fused step: the adder carry lands directly in A's MSB
            r_c <= 1'b0;
            r_a <= {w_cout, w_sum[N-1:1]};
            r_q <= {w_sum[0], r_q[N-1:1]};
        end else if (add) begin
            r_c <= w_cout;
            r_a <= w_sum;
        end else if (shift) begin
            r_c <= 1'b0;
            r_a <= {r_c, r_a[N-1:1]};
            r_q <= {r_a[0], r_q[N-1:1]};
        end
    end

    assign Q0      = r_q[0];
    assign product = {r_a, r_q};

endmodule

// File: tb/tb_multiplier_datapath.sv
// Directed bench for multiplier_datapath: reference model feeds a scoreboard queue, checked one cycle later.
module tb_multiplier_datapath;

    localparam int N = 8;

    logic           clock = 1'b0;
    logic           n_reset;
    logic           reset;
    logic           add;
    logic           shift;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic           Q0;
    logic [2*N-1:0] product;

    typedef struct {
        logic           q0;
        logic [2*N-1:0] prod;
    } exp_t;

    exp_t sb[$];

    logic [N-1:0] m_m;
    logic [N-1:0] m_a;
    logic [N-1:0] m_q;
    logic         m_c;

    int n_cmp = 0;
    int n_err = 0;

    multiplier_datapath #(.N(N)) dut (
        .clock        (clock),
        .n_reset      (n_reset),
        .reset        (reset),
        .add          (add),
        .shift        (shift),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .Q0           (Q0),
        .product      (product)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_m = '0;
        m_a = '0;
        m_q = '0;
        m_c = 1'b0;
    endtask

    task automatic model_cmd(input logic r, input logic a, input logic s,
                             input logic [N-1:0] mc, input logic [N-1:0] mp);
        int          sum;
        logic [2*N:0] chain;
        sum = int'(m_a) + int'(m_m);
        if (r) begin
            m_m = mc;
            m_q = mp;
            m_a = '0;
            m_c = 1'b0;
        end else if (a && s) begin
            chain = {1'(sum >> N), N'(sum), m_q};
            chain = chain >> 1;
            {m_c, m_a, m_q} = chain;
        end else if (a) begin
            m_c = 1'(sum >> N);
            m_a = N'(sum);
        end else if (s) begin
            chain = {m_c, m_a, m_q};
            chain = chain >> 1;
            {m_c, m_a, m_q} = chain;
        end
    endtask

    task automatic drive(input logic r, input logic a, input logic s,
                         input logic [N-1:0] mc, input logic [N-1:0] mp, input string tag);
        exp_t e;
        @(negedge clock);
        reset        = r;
        add          = a;
        shift        = s;
        multiplicand = mc;
        multiplier   = mp;
        check({tag, "_cmd_known"}, 32'($isunknown({reset, add, shift})), 32'd0);
        model_cmd(r, a, s, mc, mp);
        e.q0   = m_q[0];
        e.prod = {m_a, m_q};
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check({tag, "_q0"}, 32'(Q0), 32'(e.q0));
        check({tag, "_prod"}, 32'(product), 32'(e.prod));
    endtask

    // Sequencer-style steps; operands wander to show they are ignored without a load.
    task automatic run_steps(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, m_q[0], 1'b1, N'($urandom), N'($urandom), tag);
        end
    endtask

    initial begin
        n_reset      = 1'b0;
        reset        = 1'b0;
        add          = 1'b0;
        shift        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        model_clear();

        // async reset held with random commands
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            {reset, add, shift} = 3'($urandom);
            multiplicand = N'($urandom);
            multiplier   = N'($urandom);
            @(posedge clock);
            #1;
            check("rst_q0", 32'(Q0), 32'd0);
            check("rst_prod", 32'(product), 32'd0);
        end
        @(negedge clock);
        {reset, add, shift} = 3'b000;
        n_reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h55, 8'hAA, "post_rst");
        check("post_rst_zero", 32'(product), 32'd0);

        // 13 x 11
        drive(1'b1, 1'b0, 1'b0, 8'd13, 8'd11, "load13x11");
        run_steps(N, "run13x11");
        check("p13x11", 32'(product), 32'h008F);

        // 255 x 255
        drive(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, "load255");
        run_steps(N, "run255");
        check("p255x255", 32'(product), 32'hFE01);
        check("c255x255", 32'(dut.r_c), 32'd0);

        // build A = F0 with M = 20, then add-only and shift-only
        drive(1'b1, 1'b0, 1'b0, 8'h20, 8'h00, "load20");
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, "acc_e0");
        drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, "sh70");
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, "acc_f0");
        check("a_f0", 32'(product[2*N-1:N]), 32'hF0);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, "add_only");
        check("a_10", 32'(product[2*N-1:N]), 32'h10);
        check("c_1", 32'(dut.r_c), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, "shift_only");
        check("a_88", 32'(product[2*N-1:N]), 32'h88);
        check("q7_0", 32'(product[N-1]), 32'd0);
        check("c_0", 32'(dut.r_c), 32'd0);

        // abort mid-run with new operands
        drive(1'b1, 1'b0, 1'b0, 8'd13, 8'd11, "load_abort");
        run_steps(4, "run_abort");
        drive(1'b1, 1'b0, 1'b0, 8'd7, 8'd6, "load7x6");
        run_steps(N, "run7x6");
        check("p7x6", 32'(product), 32'd42);

        // reset wins over add and over add&shift
        drive(1'b1, 1'b1, 1'b0, 8'h5A, 8'h3C, "rst_add");
        check("rst_add_prod", 32'(product), 32'h003C);
        drive(1'b1, 1'b1, 1'b1, 8'hA5, 8'hC3, "rst_add_sh");
        check("rst_add_sh_prod", 32'(product), 32'h00C3);

        // multiplier = 0: Q0 never rises
        drive(1'b1, 1'b0, 1'b0, 8'hAB, 8'h00, "load_mp0");
        for (int i = 0; i < N; i++) begin
            drive(1'b0, m_q[0], 1'b1, 8'hFF, 8'hFF, "run_mp0");
            check("mp0_q0", 32'(Q0), 32'd0);
        end
        check("p_mp0", 32'(product), 32'd0);

        // multiplicand = 0
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'hB7, "load_mc0");
        run_steps(N, "run_mc0");
        check("p_mc0", 32'(product), 32'd0);

        // async reset asserted mid-cycle during a run
        drive(1'b1, 1'b0, 1'b0, 8'hC9, 8'h77, "load_async");
        run_steps(3, "run_async");
        #3;
        n_reset = 1'b0;
        #1;
        check("async_prod", 32'(product), 32'd0);
        check("async_q0", 32'(Q0), 32'd0);
        model_clear();
        @(negedge clock);
        {reset, add, shift} = 3'b000;
        n_reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, "async_hold");
        check("async_hold_zero", 32'(product), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
